// File: rtl/id_stage.sv
// Decode stage: instruction decode, 16x32 register file, condition check and ID/EX register.
// Define ID_WB_BYPASS_EN to forward a same-cycle write-back value onto the register reads.
module id_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic        freeze,
    input  logic        flush,
    input  logic [31:0] pc_in,
    input  logic [31:0] instruction,
    input  logic        wb_en,
    input  logic [3:0]  wb_dest,
    input  logic [31:0] wb_value,
    input  logic [3:0]  sr,
    output logic [3:0]  src1,
    output logic [3:0]  src2,
    output logic        two_src,
    output logic [31:0] pc_out,
    output logic [31:0] val_rn,
    output logic [31:0] val_rm,
    output logic        imm,
    output logic        s,
    output logic        b,
    output logic        mem_r_en,
    output logic        mem_w_en,
    output logic        wb_en_out,
    output logic [3:0]  exe_cmd,
    output logic [3:0]  dest,
    output logic [11:0] shift_operand,
    output logic [23:0] signed_imm_24,
    output logic        carry_in
);

    localparam int unsigned DATA_W = 32;
    localparam int unsigned IDX_W  = 4;
    localparam int unsigned NREGS  = 16;

    logic [DATA_W-1:0] rf [NREGS];

    logic [3:0]  cond;
    logic [1:0]  mode;
    logic        i_bit;
    logic [3:0]  opcode;
    logic        s_bit;
    logic        is_str;
    logic [IDX_W-1:0] rn_idx;
    logic [IDX_W-1:0] rd_idx;
    logic [IDX_W-1:0] rm_idx;

    assign cond   = instruction[31:28];
    assign mode   = instruction[27:26];
    assign i_bit  = instruction[25];
    assign opcode = instruction[24:21];
    assign s_bit  = instruction[20];
    assign rn_idx = instruction[19:16];
    assign rd_idx = instruction[15:12];
    assign rm_idx = instruction[3:0];

    assign is_str  = (mode == 2'b01) && !s_bit;
    assign src1    = rn_idx;
    assign src2    = is_str ? rd_idx : rm_idx;
    assign two_src = ((mode == 2'b00) && !i_bit) || is_str;

    // Register file: asynchronous read, write-back on the rising edge
    always_ff @(posedge clk) begin
        if (!rst) begin
            rf <= '{default: '0};
        end else if (wb_en) begin
            rf[wb_dest] <= wb_value;
        end
    end

    logic [DATA_W-1:0] rd_rn;
    logic [DATA_W-1:0] rd_rm;

`ifdef ID_WB_BYPASS_EN
    assign rd_rn = (wb_en && (wb_dest == src1)) ? wb_value : rf[src1];
    assign rd_rm = (wb_en && (wb_dest == src2)) ? wb_value : rf[src2];
`else
    assign rd_rn = rf[src1];
    assign rd_rm = rf[src2];
`endif

    logic n_flag, z_flag, c_flag, v_flag;
    assign n_flag = sr[3];
    assign z_flag = sr[2];
    assign c_flag = sr[1];
    assign v_flag = sr[0];

    logic cond_ok;

    always_comb begin
        cond_ok = 1'b0;
        case (cond)
            4'b0000: cond_ok = z_flag;
            4'b0001: cond_ok = !z_flag;
            4'b0010: cond_ok = c_flag;
            4'b0011: cond_ok = !c_flag;
            4'b0100: cond_ok = n_flag;
            4'b0101: cond_ok = !n_flag;
            4'b0110: cond_ok = v_flag;
            4'b0111: cond_ok = !v_flag;
            4'b1000: cond_ok = c_flag && !z_flag;
            4'b1001: cond_ok = !c_flag || z_flag;
            4'b1010: cond_ok = (n_flag == v_flag);
            4'b1011: cond_ok = (n_flag != v_flag);
            4'b1100: cond_ok = !z_flag && (n_flag == v_flag);
            4'b1101: cond_ok = z_flag || (n_flag != v_flag);
            4'b1110: cond_ok = 1'b1;
            default: cond_ok = 1'b0;
        endcase
    end

    logic [3:0] dec_cmd;
    logic       dec_wb, dec_mr, dec_mw, dec_b, dec_s;

    // Control decode; conditional control bits are squashed when the condition fails
    always_comb begin
        dec_cmd = 4'b0000;
        dec_wb  = 1'b0;
        dec_mr  = 1'b0;
        dec_mw  = 1'b0;
        dec_b   = 1'b0;
        dec_s   = 1'b0;
        case (mode)
            2'b00: begin
                dec_s  = s_bit;
                dec_wb = (opcode != 4'b1010) && (opcode != 4'b1000);
                case (opcode)
                    4'b1101: dec_cmd = 4'b0001;
                    4'b1111: dec_cmd = 4'b1001;
                    4'b0100: dec_cmd = 4'b0010;
                    4'b0101: dec_cmd = 4'b0011;
                    4'b0010: dec_cmd = 4'b0100;
                    4'b0110: dec_cmd = 4'b0101;
                    4'b0000: dec_cmd = 4'b0110;
                    4'b1100: dec_cmd = 4'b0111;
                    4'b0001: dec_cmd = 4'b1000;
                    4'b1010: dec_cmd = 4'b0100;
                    4'b1000: dec_cmd = 4'b0110;
                    default: dec_cmd = 4'b0000;
                endcase
            end
            2'b01: begin
                dec_cmd = 4'b0010;
                dec_mr  = s_bit;
                dec_wb  = s_bit;
                dec_mw  = !s_bit;
            end
            2'b10: dec_b = 1'b1;
            default: ;
        endcase
        if (!cond_ok) begin
            dec_wb = 1'b0;
            dec_mr = 1'b0;
            dec_mw = 1'b0;
            dec_b  = 1'b0;
            dec_s  = 1'b0;
        end
    end

    // ID/EX register: reset > flush > freeze > load
    always_ff @(posedge clk) begin
        if (!rst || flush) begin
            pc_out        <= '0;
            val_rn        <= '0;
            val_rm        <= '0;
            imm           <= 1'b0;
            s             <= 1'b0;
            b             <= 1'b0;
            mem_r_en      <= 1'b0;
            mem_w_en      <= 1'b0;
            wb_en_out     <= 1'b0;
            exe_cmd       <= '0;
            dest          <= '0;
            shift_operand <= '0;
            signed_imm_24 <= '0;
            carry_in      <= 1'b0;
        end else if (!freeze) begin
            pc_out        <= pc_in;
            val_rn        <= rd_rn;
            val_rm        <= rd_rm;
            imm           <= i_bit;
            s             <= dec_s;
            b             <= dec_b;
            mem_r_en      <= dec_mr;
            mem_w_en      <= dec_mw;
            wb_en_out     <= dec_wb;
            exe_cmd       <= dec_cmd;
            dest          <= rd_idx;
            shift_operand <= instruction[11:0];
            signed_imm_24 <= instruction[23:0];
            carry_in      <= c_flag;
        end
    end

endmodule

// File: tb/tb_id_stage.sv
// Self-checking bench for id_stage: directed scenarios followed by randomized traffic
// compared against a behavioural model of decode, register file and ID/EX register.
module tb_id_stage;

    logic        clk;
    logic        rst;
    logic        freeze;
    logic        flush;
    logic [31:0] pc_in;
    logic [31:0] instruction;
    logic        wb_en;
    logic [3:0]  wb_dest;
    logic [31:0] wb_value;
    logic [3:0]  sr;
    logic [3:0]  src1, src2;
    logic        two_src;
    logic [31:0] pc_out, val_rn, val_rm;
    logic        imm, s, b, mem_r_en, mem_w_en, wb_en_out;
    logic [3:0]  exe_cmd, dest;
    logic [11:0] shift_operand;
    logic [23:0] signed_imm_24;
    logic        carry_in;

    id_stage dut (
        .clk(clk), .rst(rst), .freeze(freeze), .flush(flush),
        .pc_in(pc_in), .instruction(instruction),
        .wb_en(wb_en), .wb_dest(wb_dest), .wb_value(wb_value), .sr(sr),
        .src1(src1), .src2(src2), .two_src(two_src),
        .pc_out(pc_out), .val_rn(val_rn), .val_rm(val_rm),
        .imm(imm), .s(s), .b(b), .mem_r_en(mem_r_en), .mem_w_en(mem_w_en),
        .wb_en_out(wb_en_out), .exe_cmd(exe_cmd), .dest(dest),
        .shift_operand(shift_operand), .signed_imm_24(signed_imm_24),
        .carry_in(carry_in)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] rn;
        logic [31:0] rm;
        logic        imm;
        logic        s;
        logic        b;
        logic        mr;
        logic        mw;
        logic        wb;
        logic [3:0]  cmd;
        logic [3:0]  dest;
        logic [11:0] sh;
        logic [23:0] si;
        logic        cin;
    } idex_t;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;
    logic [31:0] m_rf [16];
    idex_t       m_q;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic bit cond_holds(input logic [3:0] c, input logic [3:0] f);
        bit n, z, cf, v;
        n = f[3]; z = f[2]; cf = f[1]; v = f[0];
        case (c)
            0:  return z;
            1:  return !z;
            2:  return cf;
            3:  return !cf;
            4:  return n;
            5:  return !n;
            6:  return v;
            7:  return !v;
            8:  return cf && !z;
            9:  return !cf || z;
            10: return n == v;
            11: return n != v;
            12: return !z && (n == v);
            13: return z || (n != v);
            14: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    // Reference decode written from the mnemonic table
    function automatic idex_t model_decode(input logic [31:0] ins, input logic [31:0] pc,
                                           input logic [31:0] rn_v, input logic [31:0] rm_v,
                                           input logic [3:0] flags);
        idex_t r;
        logic [3:0] op;
        r = '0;
        op = ins[24:21];
        r.pc = pc; r.rn = rn_v; r.rm = rm_v;
        r.imm = ins[25]; r.dest = ins[15:12]; r.sh = ins[11:0]; r.si = ins[23:0];
        r.cin = flags[1];
        if (ins[27:26] == 2'd0) begin
            case (op)
                4'hD: r.cmd = 4'd1;  // MOV
                4'hF: r.cmd = 4'd9;  // MVN
                4'h4: r.cmd = 4'd2;  // ADD
                4'h5: r.cmd = 4'd3;  // ADC
                4'h2: r.cmd = 4'd4;  // SUB
                4'h6: r.cmd = 4'd5;  // SBC
                4'h0: r.cmd = 4'd6;  // AND
                4'hC: r.cmd = 4'd7;  // ORR
                4'h1: r.cmd = 4'd8;  // EOR
                4'hA: r.cmd = 4'd4;  // CMP
                4'h8: r.cmd = 4'd6;  // TST
                default: r.cmd = 4'd0;
            endcase
            r.s  = ins[20];
            r.wb = !(op == 4'hA || op == 4'h8);
        end else if (ins[27:26] == 2'd1) begin
            r.cmd = 4'd2;
            if (ins[20]) begin r.mr = 1'b1; r.wb = 1'b1; end
            else         r.mw = 1'b1;
        end else if (ins[27:26] == 2'd2) begin
            r.b = 1'b1;
        end
        if (!cond_holds(ins[31:28], flags)) begin
            r.wb = 1'b0; r.mr = 1'b0; r.mw = 1'b0; r.b = 1'b0; r.s = 1'b0;
        end
        return r;
    endfunction

    task automatic check_outputs();
        check("pc_out",        pc_out,                  m_q.pc);
        check("val_rn",        val_rn,                  m_q.rn);
        check("val_rm",        val_rm,                  m_q.rm);
        check("imm",           32'(imm),                32'(m_q.imm));
        check("s",             32'(s),                  32'(m_q.s));
        check("b",             32'(b),                  32'(m_q.b));
        check("mem_r_en",      32'(mem_r_en),           32'(m_q.mr));
        check("mem_w_en",      32'(mem_w_en),           32'(m_q.mw));
        check("wb_en_out",     32'(wb_en_out),          32'(m_q.wb));
        check("exe_cmd",       32'(exe_cmd),            32'(m_q.cmd));
        check("dest",          32'(dest),               32'(m_q.dest));
        check("shift_operand", 32'(shift_operand),      32'(m_q.sh));
        check("signed_imm_24", 32'(signed_imm_24),      32'(m_q.si));
        check("carry_in",      32'(carry_in),           32'(m_q.cin));
    endtask

    // One clock: check the combinational outputs, advance model at the edge, check registers
    task automatic step();
        logic [3:0]  s1, s2;
        logic [31:0] rn_v, rm_v;
        bit          str_op;
        #1;
        s1     = instruction[19:16];
        str_op = (instruction[27:26] == 2'b01) && !instruction[20];
        s2     = str_op ? instruction[15:12] : instruction[3:0];
        check("src1",    32'(src1),    32'(s1));
        check("src2",    32'(src2),    32'(s2));
        check("two_src", 32'(two_src), 32'(str_op || (instruction[27:25] == 3'b000)));
        @(posedge clk);
        rn_v = m_rf[s1];
        rm_v = m_rf[s2];
`ifdef ID_WB_BYPASS_EN
        if (wb_en && wb_dest == s1) rn_v = wb_value;
        if (wb_en && wb_dest == s2) rm_v = wb_value;
`endif
        if (!rst) begin
            m_q = '0;
            for (int i = 0; i < 16; i++) m_rf[i] = '0;
        end else begin
            if (flush)        m_q = '0;
            else if (!freeze) m_q = model_decode(instruction, pc_in, rn_v, rm_v, sr);
            if (wb_en) m_rf[wb_dest] = wb_value;
        end
        #1;
        check_outputs();
    endtask

    logic [3:0] dp_ops [11] = '{4'hD, 4'hF, 4'h4, 4'h5, 4'h2, 4'h6, 4'h0, 4'hC, 4'h1, 4'hA, 4'h8};

    initial begin
        rst = 1'b0; freeze = 1'b0; flush = 1'b0; pc_in = 32'h0;
        instruction = 32'hE3A00014; wb_en = 1'b0; wb_dest = 4'd0; wb_value = '0; sr = 4'h0;
        m_q = '0;
        for (int i = 0; i < 16; i++) m_rf[i] = '0;

        // Reset with a new instruction present, then read R5
        step();
        check("rst_wb_en_out", 32'(wb_en_out), 32'd0);
        rst = 1'b1; instruction = 32'hE0850005; pc_in = 32'h4;
        step();
        check("rst_r5", val_rn, 32'd0);

        // MOV R0,#20
        instruction = 32'hE3A00014; pc_in = 32'h8;
        step();
        check("mov_cmd", 32'(exe_cmd), 32'd1);
        check("mov_imm", 32'(imm), 32'd1);
        check("mov_wb", 32'(wb_en_out), 32'd1);
        check("mov_shift", 32'(shift_operand), 32'h014);

        // WB R2 then ADDS R3,R2,R2
        wb_en = 1'b1; wb_dest = 4'd2; wb_value = 32'hC000_0000;
        step();
        wb_en = 1'b0; instruction = 32'hE0923002; pc_in = 32'hC;
        step();
        check("adds_rn", val_rn, 32'hC000_0000);
        check("adds_rm", val_rm, 32'hC000_0000);
        check("adds_s", 32'(s), 32'd1);
        check("adds_cmd", 32'(exe_cmd), 32'd2);

        // ADDNE with Z set, then clear
        instruction = 32'h10811001; sr = 4'b0100;
        step();
        check("addne_z1_wb", 32'(wb_en_out), 32'd0);
        sr = 4'b0000;
        step();
        check("addne_z0_wb", 32'(wb_en_out), 32'd1);

        // STR, freeze with a new instruction, then flush with freeze
        instruction = 32'hE4801000; pc_in = 32'h10;
        step();
        check("str_mw", 32'(mem_w_en), 32'd1);
        freeze = 1'b1; instruction = 32'hE3A00014; pc_in = 32'h14;
        wb_en = 1'b1; wb_dest = 4'd7; wb_value = 32'h1234_5678;
        step();
        check("frz_mw", 32'(mem_w_en), 32'd1);
        wb_en = 1'b0; flush = 1'b1;
        step();
        check("flush_mw", 32'(mem_w_en), 32'd0);
        flush = 1'b0; freeze = 1'b0; instruction = 32'hE0877007;
        step();
        check("frz_wb_written", val_rn, 32'h1234_5678);

        // Same-cycle write-back and read of R4
        wb_en = 1'b1; wb_dest = 4'd4; wb_value = 32'd7;
        step();
        wb_value = 32'd41; instruction = 32'hE0840000;
        step();
`ifdef ID_WB_BYPASS_EN
        check("same_cycle_r4", val_rn, 32'd41);
`else
        check("same_cycle_r4", val_rn, 32'd7);
`endif
        wb_en = 1'b0;

        // Randomized traffic
        for (int k = 0; k < 400; k++) begin
            instruction = $urandom;
            case ($urandom_range(0, 5))
                0, 1, 2: begin
                    instruction[27:26] = 2'b00;
                    instruction[24:21] = dp_ops[$urandom_range(0, 10)];
                end
                3, 4:    instruction[27:26] = 2'b01;
                default: instruction[27:26] = 2'b10;
            endcase
            pc_in    = $urandom;
            sr       = 4'($urandom);
            rst      = ($urandom_range(0, 49) != 0);
            freeze   = ($urandom_range(0, 5) == 0);
            flush    = ($urandom_range(0, 7) == 0);
            wb_en    = 1'($urandom);
            wb_dest  = ($urandom_range(0, 2) == 0) ? instruction[19:16] : 4'($urandom);
            wb_value = $urandom;
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/id_stage.md
# id_stage

Instruction-decode stage of the five-stage ARM-subset pipeline: takes the fetched PC and instruction word from the fetch stage, decodes them, reads the 16-entry register file, and evaluates the condition field against the status flags. The result is captured in the ID/EX pipeline register that feeds execute. The stage also owns the register-file write port driven by write-back, and exposes source-register indices to the hazard unit.

## Interface
- No parameters; widths fixed: data 32, register index 4, 16 registers.
- clk  in  1  rising-edge clock; the only clock.
- rst  in  1  synchronous, active-low reset.
- freeze  in  1  hazard stall; ID/EX register holds its value.
- flush  in  1  branch taken in EXE; next edge loads a bubble.
- pc_in  in  32  PC+4 of the instruction being decoded.
- instruction  in  32  instruction word from fetch.
- wb_en / wb_dest / wb_value  in  1/4/32  register-file write port.
- sr  in  4  status flags {N,Z,C,V}.
- src1, src2  out  4  combinational: Rn=[19:16]; src2 = Rd [15:12] for STR, else Rm [3:0].
- two_src  out  1  combinational: high for register-operand data processing (mode 00, I=0) or STR.
- pc_out, val_rn, val_rm  out  32  registered.
- imm, s, b, mem_r_en, mem_w_en, wb_en_out  out  1  registered.
- exe_cmd  out  4, dest  out  4, shift_operand  out  12, signed_imm_24  out  24, carry_in  out  1  registered (carry_in = sr C).

## Operation
- Fields: cond [31:28], mode [27:26], I [25], opcode [24:21], S [20], Rn, Rd, shifter [11:0], imm24 [23:0].
- exe_cmd by opcode (mode 00): MOV 1101→0001, MVN 1111→1001, ADD 0100→0010, ADC 0101→0011, SUB 0010→0100, SBC 0110→0101, AND 0000→0110, ORR 1100→0111, EOR 0001→1000, CMP 1010→0100, TST 1000→0110. Mode 01 (LDR when S=1, STR when S=0) → 0010. Mode 10 → b=1, exe_cmd don't-care (0000).
- wb_en_out: data processing except CMP/TST, and LDR. mem_r_en: LDR. mem_w_en: STR. s: instruction S bit for data processing; CMP/TST set only flags.
- Condition check: EQ Z, NE !Z, CS C, CC !C, MI N, PL !N, VS V, VC !V, HI C&!Z, LS !C|Z, GE N==V, LT N!=V, GT !Z&(N==V), LE Z|(N!=V), AL 1, 1111 → 0.
- Condition fails: wb_en_out, mem_r_en, mem_w_en, b, s forced 0; data fields still loaded.
- Register file: 16×32, asynchronous read at src1/src2, write on rising edge when wb_en, reset clears all entries to 0.
- Pipeline register priority: reset > flush > freeze > load. Flush loads all outputs 0. Freeze holds all registered outputs; register-file writes and combinational src outputs continue during freeze.

## Timing
- Decode latency 1 cycle: instruction present before edge N appears on outputs after edge N.
- Reset: every registered output 0; register file 0; takes effect at the first rising edge with rst=0, including mid-stall.
- flush and freeze asserted together: bubble loaded (flush wins).
- Write-back and read of the same register in one cycle: read returns old value unless ID_WB_BYPASS_EN is defined.
- wb_dest write while freeze=1: write completes; held ID/EX values are not refreshed.

## Configuration
- ID_WB_BYPASS_EN defined: when wb_en=1 and wb_dest equals src1 or src2, the matching val_rn/val_rm read returns wb_value in the same cycle (write-through).
- Undefined: reads return the stored entry; hazard unit must stall one extra cycle for write-back conflicts.

## Test plan
- Reset: rst=0 one edge → all outputs 0; read R5 → 0.
- MOV R0,#20 (0xE3A00014), AL → exe_cmd=0001, imm=1, dest=0, wb_en_out=1, shift_operand=0x014 after one edge.
- Write R2=0xC0000000 via WB, then ADDS R3,R2,R2 (0xE0923002) → val_rn=val_rm=0xC0000000, s=1, exe_cmd=0010, two_src=1.
- ADDNE (0x10811001) with sr Z=1 → wb_en_out=0; with Z=0 → wb_en_out=1.
- STR R1,[R0] (0xE4801000) → mem_w_en=1, src2=1, two_src=1; freeze=1 with new instruction → outputs unchanged; flush=1 with freeze=1 → all outputs 0.
- Same-cycle WB R4=41 and read R4: with ID_WB_BYPASS_EN val_rn=41, without → previous value.
